ssp_rx_ctrl: RTL and testbench
==============================

// Module: ssp_rx_ctrl
// PURPOSE
//  Receive-side sequencer of the SSP; all logic runs on PCLK.
//  - Deserialises SSPRXD into 8-bit words using TI synchronous-serial framing: SSPFSSIN frames each word, data is MSB first.
//  - Feeds each completed word to the RX FIFO through RxData/NextWord.
//  - Refuses pushes when the FIFO is full and flags overrun.
// PARAMETERS
//  WORD_BITS  8  bits per serial frame; sets the RxData width and the bit-counter terminal value
// PORTS
//  PCLK        in   1          system clock; all state changes on rising edge
//  CLEAR_B     in   1          asynchronous, active-low reset
//  SSPCLKIN    in   1          serial bit clock, at most PCLK/4
//  SSPFSSIN    in   1          frame sync, high for one SSPCLKIN period before the MSB
//  SSPRXD      in   1          serial receive data
//  RxFifoFull  in   1          RX FIFO cannot accept a word this cycle
//  OverrunClr  in   1          one-cycle pulse; clears RxOverrun
//  RxData      out  WORD_BITS  last completed word; held until the next word completes
//  NextWord    out  1          one-PCLK push strobe to the RX FIFO
//  RxBusy      out  1          high while a frame is being shifted in
//  RxOverrun   out  1          sticky: a completed word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (CLEAR_B low, async): state=IDLE, count=0, shift reg=0, RxData=0, NextWord=0, RxBusy=0, RxOverrun=0.
//    Reset mid-frame discards the partial word.
//  Sample event "fall": registered previous SCLK=1 and current SCLK=0 (SCLK = SSPCLKIN after optional sync).
//    SSPFSSIN and SSPRXD are sampled at the same PCLK edge as the fall.
//  FSM:
//    IDLE : fall & FSS=1 -> SHIFT, count=0. Otherwise stay.
//    SHIFT: each fall shifts RXD into the LSB of the shift reg, count++.
//           Fall with count=WORD_BITS-1 completes the word -> DONE.
//           FSS=1 on a fall with count<WORD_BITS-1 is a resync: discard partial word, count=0, stay in SHIFT.
//    DONE : one PCLK cycle. If RxFifoFull=0: RxData<=word, NextWord=1 this cycle.
//           If RxFifoFull=1: word dropped, RxData unchanged, NextWord=0, RxOverrun<=1.
//           Next state is SHIFT (count=0) if FSS was 1 at the completing fall (back-to-back frame), else IDLE.
//  Latency: NextWord and the new RxData appear exactly 1 PCLK after the PCLK edge that sampled the LSB fall.
//    Add 2 PCLK when sync is enabled.
//  NextWord: never high for two consecutive cycles; at most one pulse per frame.
//  RxBusy: high in SHIFT and DONE.
//  RxOverrun: cleared by OverrunClr. If set and clear happen in the same cycle, set wins.
//  A fall occurring during DONE cannot happen (SSPCLKIN <= PCLK/4); no requirement beyond that.
// CONFIGURATION
//  SSP_RX_SYNC_EN defined: SSPCLKIN, SSPFSSIN and SSPRXD each pass through a 2-flop synchroniser (reset 0) before edge detect.
//    Latency +2 PCLK.
//  SSP_RX_SYNC_EN undefined: inputs are used directly and must be synchronous to PCLK. Same behaviour otherwise.
// STRUCTURE
//  ssp_defs.vh (shared by the SSP tx/rx blocks): state encodings ST_IDLE/ST_SHIFT/ST_DONE, SSP_WORD_BITS=8.
//  Sub-module ssp_edge_sync: optional synchroniser for the three inputs plus the SCLK fall detector.
//    Outputs: fall, fss_s, rxd_s.
//  Top level holds the FSM, bit counter, shift register, output registers and overrun flag.
// TESTING
//  1. Single frame 0xA5, FIFO not full -> exactly one NextWord pulse, RxData=0xA5, RxOverrun=0, RxBusy drops after DONE.
//  2. Back-to-back frames 0x3C then 0xC3 (FSS high during LSB)
//     -> two NextWord pulses, WORD_BITS SCLK periods apart, RxData 0x3C then 0xC3; no IDLE in between.
//  3. Frame 0x55 with RxFifoFull=1 at completion -> no NextWord, RxData keeps its prior value, RxOverrun=1.
//     Then OverrunClr pulse -> RxOverrun=0. Set and clear in the same cycle -> RxOverrun stays 1.
//  4. FSS re-asserted after 4 bits, then a full frame 0x81 -> only 0x81 pushed; partial word never pushed.
//  5. CLEAR_B low mid-frame after 5 bits, released, then frame 0x0F
//     -> all outputs 0 during reset; only 0x0F pushed afterwards.
//  6. Both builds (SSP_RX_SYNC_EN on/off) on test 1: NextWord timing differs by exactly 2 PCLK; data identical.

Source files
------------

// File: rtl/ssp_rx_ctrl_pkg.sv
// Shared definitions for the SSP receive sequencer: word size and FSM state encoding.
package ssp_rx_ctrl_pkg;

  localparam int unsigned SSP_WORD_BITS = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } ssp_state_e;

endpackage

// File: rtl/ssp_rx_ctrl_edge_sync.sv
// Optional 2-flop synchronisers for SSPCLKIN/SSPFSSIN/SSPRXD plus the serial-clock fall detector.
// Synchronisers are built only when SSP_RX_SYNC_EN is defined.
module ssp_rx_ctrl_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic fss_i,
  input  logic rxd_i,
  output logic fall_o,
  output logic fss_o,
  output logic rxd_o
);

  logic sclk_s;
  logic sclk_prev_q;

`ifdef SSP_RX_SYNC_EN
  logic [1:0] sclk_sync_q;
  logic [1:0] fss_sync_q;
  logic [1:0] rxd_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= 2'b00;
      fss_sync_q  <= 2'b00;
      rxd_sync_q  <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      fss_sync_q  <= {fss_sync_q[0], fss_i};
      rxd_sync_q  <= {rxd_sync_q[0], rxd_i};
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign fss_o  = fss_sync_q[1];
  assign rxd_o  = rxd_sync_q[1];
`else
  assign sclk_s = sclk_i;
  assign fss_o  = fss_i;
  assign rxd_o  = rxd_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
    end
  end

  // Frame sync and data are taken on the same PCLK edge that sees the fall.
  assign fall_o = sclk_prev_q & ~sclk_s;

endmodule

// File: rtl/ssp_rx_ctrl.sv
// SSP receive sequencer: TI-framed, MSB-first deserialiser feeding the RX FIFO with overrun flag.
// Define SSP_RX_SYNC_EN to synchronise the serial inputs to PCLK (adds 2 PCLK latency).
module ssp_rx_ctrl
  import ssp_rx_ctrl_pkg::*;
#(
  parameter int unsigned WORD_BITS = SSP_WORD_BITS
) (
  input  logic                 PCLK,
  input  logic                 CLEAR_B,
  input  logic                 SSPCLKIN,
  input  logic                 SSPFSSIN,
  input  logic                 SSPRXD,
  input  logic                 RxFifoFull,
  input  logic                 OverrunClr,
  output logic [WORD_BITS-1:0] RxData,
  output logic                 NextWord,
  output logic                 RxBusy,
  output logic                 RxOverrun
);

  localparam int unsigned CntW = $clog2(WORD_BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_BITS - 1);

  logic fall;
  logic fss_s;
  logic rxd_s;

  ssp_state_e           state_q;
  logic [CntW-1:0]      count_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] rx_data_q;
  logic                 next_word_q;
  logic                 rx_busy_q;
  logic                 overrun_q;
  logic                 b2b_q;

  ssp_rx_ctrl_edge_sync u_edge_sync (
    .clk_i  (PCLK),
    .rst_ni (CLEAR_B),
    .sclk_i (SSPCLKIN),
    .fss_i  (SSPFSSIN),
    .rxd_i  (SSPRXD),
    .fall_o (fall),
    .fss_o  (fss_s),
    .rxd_o  (rxd_s)
  );

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q     <= StIdle;
      count_q     <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      next_word_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      overrun_q   <= 1'b0;
      b2b_q       <= 1'b0;
    end else begin
      next_word_q <= 1'b0;
      if (OverrunClr) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (fall && fss_s) begin
            state_q   <= StShift;
            count_q   <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        StShift: begin
          if (fall) begin
            if (count_q == LastBit) begin
              shift_q <= {shift_q[WORD_BITS-2:0], rxd_s};
              b2b_q   <= fss_s;
              state_q <= StDone;
            end else if (fss_s) begin
              // Resync: a new frame starts before the current one finished.
              shift_q <= '0;
              count_q <= '0;
            end else begin
              shift_q <= {shift_q[WORD_BITS-2:0], rxd_s};
              count_q <= count_q + 1'b1;
            end
          end
        end
        StDone: begin
          // Setting overrun here overrides a same-cycle OverrunClr above.
          if (!RxFifoFull) begin
            rx_data_q   <= shift_q;
            next_word_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          count_q <= '0;
          if (b2b_q) begin
            state_q <= StShift;
          end else begin
            state_q   <= StIdle;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign RxData    = rx_data_q;
  assign NextWord  = next_word_q;
  assign RxBusy    = rx_busy_q;
  assign RxOverrun = overrun_q;

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// Directed scoreboard bench for ssp_rx_ctrl; build with or without SSP_RX_SYNC_EN.
module tb_ssp_rx_ctrl;

`ifdef SSP_RX_SYNC_EN
  localparam int ExpLat = 4;
`else
  localparam int ExpLat = 2;
`endif
  localparam int BitPclk = 7;

  logic       PCLK;
  logic       CLEAR_B;
  logic       SSPCLKIN;
  logic       SSPFSSIN;
  logic       SSPRXD;
  logic       RxFifoFull;
  logic       OverrunClr;
  logic [7:0] RxData;
  logic       NextWord;
  logic       RxBusy;
  logic       RxOverrun;

  ssp_rx_ctrl #(
    .WORD_BITS(8)
  ) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .SSPCLKIN  (SSPCLKIN),
    .SSPFSSIN  (SSPFSSIN),
    .SSPRXD    (SSPRXD),
    .RxFifoFull(RxFifoFull),
    .OverrunClr(OverrunClr),
    .RxData    (RxData),
    .NextWord  (NextWord),
    .RxBusy    (RxBusy),
    .RxOverrun (RxOverrun)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         last_nw_cyc = -1000;
  int         prev_nw_cyc = -1000;
  logic       last_nw_busy = 1'bx;
  logic       prev_nw_busy = 1'bx;
  logic       nw_prev = 1'b0;
  int         fall_cyc = 0;
  int         lsb_fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every push is compared against the oldest expected word.
  always @(negedge PCLK) begin
    if (NextWord === 1'b1) begin
      prev_nw_cyc  = last_nw_cyc;
      last_nw_cyc  = cyc;
      prev_nw_busy = last_nw_busy;
      last_nw_busy = RxBusy;
      check("nextword_single_cycle", {31'd0, nw_prev}, 32'd0);
      vectors++;
      assert (exp_q.size() > 0)
      else begin
        miscompares++;
        $error("FAIL unexpected_push observed=%0h expected=none", RxData);
      end
      if (exp_q.size() > 0) check("push_data", {24'd0, RxData}, {24'd0, exp_q.pop_front()});
    end
    nw_prev = NextWord;
  end

  task automatic send_bit(input logic fss, input logic rxd, input logic clr_done);
    @(posedge PCLK);
    #1;
    SSPFSSIN = fss;
    SSPRXD   = rxd;
    SSPCLKIN = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    SSPCLKIN = 1'b0;
    fall_cyc = cyc;
    if (clr_done) begin
      // Pulse OverrunClr exactly in the DONE cycle.
      repeat (ExpLat - 1) @(posedge PCLK);
      #1 OverrunClr = 1'b1;
      @(posedge PCLK);
      #1 OverrunClr = 1'b0;
    end else begin
      repeat (3) @(posedge PCLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input logic lead, input logic fss_lsb,
                            input logic clr_done);
    if (lead) send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 7; i > 0; i--) send_bit(1'b0, w[i], 1'b0);
    if (!RxFifoFull) exp_q.push_back(w);
    send_bit(fss_lsb, w[0], clr_done);
    lsb_fall_cyc = fall_cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxdata"}, {24'd0, RxData}, 32'd0);
    check({tag, "_nextword"}, {31'd0, NextWord}, 32'd0);
    check({tag, "_busy"}, {31'd0, RxBusy}, 32'd0);
    check({tag, "_overrun"}, {31'd0, RxOverrun}, 32'd0);
  endtask

  initial begin
    CLEAR_B    = 1'b0;
    SSPCLKIN   = 1'b0;
    SSPFSSIN   = 1'b0;
    SSPRXD     = 1'b0;
    RxFifoFull = 1'b0;
    OverrunClr = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 check_all_zero("reset");
    CLEAR_B = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);

    // Single frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t1_latency", last_nw_cyc - lsb_fall_cyc, ExpLat);
    check("t1_rxdata", {24'd0, RxData}, 32'hA5);
    check("t1_overrun", {31'd0, RxOverrun}, 32'd0);
    check("t1_busy_at_push", {31'd0, last_nw_busy}, 32'd0);
    check("t1_busy_idle", {31'd0, RxBusy}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // Back-to-back frames: FSS high on the LSB of the first
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t2_spacing", last_nw_cyc - prev_nw_cyc, 8 * BitPclk);
    check("t2_busy_between", {31'd0, prev_nw_busy}, 32'd1);
    check("t2_rxdata", {24'd0, RxData}, 32'hC3);
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // Overrun, clear, then set and clear in the same cycle
    RxFifoFull = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t3_overrun_set", {31'd0, RxOverrun}, 32'd1);
    check("t3_rxdata_held", {24'd0, RxData}, 32'hC3);
    @(posedge PCLK);
    #1 OverrunClr = 1'b1;
    @(posedge PCLK);
    #1 OverrunClr = 1'b0;
    check("t3_overrun_cleared", {31'd0, RxOverrun}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t3_set_wins", {31'd0, RxOverrun}, 32'd1);
    check("t3_rxdata_held2", {24'd0, RxData}, 32'hC3);
    @(posedge PCLK);
    #1 OverrunClr = 1'b1;
    RxFifoFull = 1'b0;
    @(posedge PCLK);
    #1 OverrunClr = 1'b0;
    check("t3_overrun_cleared2", {31'd0, RxOverrun}, 32'd0);

    // Resync after 4 bits
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t4_rxdata", {24'd0, RxData}, 32'h81);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-frame after 5 bits
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b0);
    @(posedge PCLK);
    #1 CLEAR_B = 1'b0;
    #1 check_all_zero("t5_in_reset");
    repeat (2) @(posedge PCLK);
    #1 CLEAR_B = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t5_rxdata", {24'd0, RxData}, 32'h0F);
    check("t5_overrun", {31'd0, RxOverrun}, 32'd0);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
